// File: rtl/iob_fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle for iob_fifo_wr_arbiter.
// master = arbiter side, slave = requesters plus FIFO side.
interface iob_fifo_wr_arbiter_if #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 16
);
   logic                              en;
   logic [N_REQ-1:0]                  req_valid;
   logic [N_REQ-1:0]                  req_last;
   logic [N_REQ*DATA_WIDTH-1:0]       req_data;
   logic [N_REQ-1:0]                  req_ready;
   logic                              fifo_full;
   logic [DATA_WIDTH-1:0]             fifo_data_in;
   logic                              fifo_write_en;
   logic                              busy;
   logic [$clog2(N_REQ)-1:0]          owner;
   logic [$clog2(MAX_BURST+1)-1:0]    burst_cnt;

   modport master (
      input  en, req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_data_in, fifo_write_en, busy, owner, burst_cnt
   );

   modport slave (
      output en, req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_data_in, fifo_write_en, busy, owner, burst_cnt
   );
endinterface

// File: rtl/iob_fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port among N_REQ requesters.
// A grant is held until the owner's last beat or MAX_BURST beats, whichever comes first.
module iob_fifo_wr_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   iob_fifo_wr_arbiter_if.master bus
);
   localparam int unsigned OWN_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam int unsigned IDX_W = OWN_W + 1;

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e           state_q, state_d;
   logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [OWN_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   logic             found;
   logic [OWN_W-1:0] win_idx;
   logic [IDX_W-1:0] idx_sum;
   logic [OWN_W-1:0] sel_idx;
   logic [N_REQ-1:0] sel_oh;
   logic [N_REQ-1:0] ready;
   logic             xfer;
   logic             sel_last;
   logic [CNT_W-1:0] cnt_inc;

   // Wrap explicitly so non-power-of-two N_REQ never aliases.
   function automatic logic [OWN_W-1:0] next_ptr(input logic [OWN_W-1:0] p);
      if (p == OWN_W'(N_REQ - 1)) return '0;
      return p + OWN_W'(1);
   endfunction

   // Round-robin search starting at rr_ptr_q.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx_sum = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx_sum = IDX_W'(rr_ptr_q) + IDX_W'(k);
         if (idx_sum >= IDX_W'(N_REQ)) idx_sum = idx_sum - IDX_W'(N_REQ);
         if (!found && bus.req_valid[idx_sum[OWN_W-1:0]]) begin
            found   = 1'b1;
            win_idx = idx_sum[OWN_W-1:0];
         end
      end
   end

   // Selection, handshake and next-state.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      sel_oh      = '0;
      sel_idx     = owner_q;
      cnt_inc     = burst_cnt_q + CNT_W'(1);

      if (state_q == LOCKED) begin
         sel_oh[owner_q] = 1'b1;
      end else if (bus.en && found) begin
         sel_idx         = win_idx;
         sel_oh[win_idx] = 1'b1;
      end

      ready    = sel_oh & {N_REQ{~bus.fifo_full & rst}};
      xfer     = |(bus.req_valid & ready);
      sel_last = bus.req_last[sel_idx];

      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               owner_d = sel_idx;
               if (sel_last || (MAX_BURST == 1)) begin
                  rr_ptr_d    = next_ptr(sel_idx);
                  burst_cnt_d = '0;
               end else begin
                  state_d     = LOCKED;
                  burst_cnt_d = CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (xfer) begin
               if (sel_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                  state_d     = IDLE;
                  rr_ptr_d    = next_ptr(owner_q);
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign bus.req_ready     = ready;
   assign bus.fifo_write_en = xfer;
   assign bus.fifo_data_in  = bus.req_data[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
   assign bus.busy          = (state_q == LOCKED);
   assign bus.owner         = owner_q;
   assign bus.burst_cnt     = burst_cnt_q;
endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Directed bench for iob_fifo_wr_arbiter: reset, round-robin, packet lock,
// FIFO-full stall, forced release at MAX_BURST=4, enable gating, mid-packet reset.
module tb_iob_fifo_wr_arbiter;
   localparam int unsigned N_REQ      = 4;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned MAX_BURST  = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   iob_fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) bus ();

   iob_fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the combinational grant/write view after inputs settle.
   task automatic chk_grant(input string tag, input logic [3:0] exp_ready, input logic [7:0] exp_data);
      #1;
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
      chk({tag, "_we"}, 32'(bus.fifo_write_en), 32'(exp_ready != 4'b0));
      if (exp_ready != 4'b0) chk({tag, "_data"}, 32'(bus.fifo_data_in), 32'(exp_data));
   endtask

   task automatic chk_regs(input string tag, input logic exp_busy, input logic [1:0] exp_owner,
                           input logic [2:0] exp_cnt);
      chk({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
      chk({tag, "_owner"}, 32'(bus.owner), 32'(exp_owner));
      chk({tag, "_cnt"}, 32'(bus.burst_cnt), 32'(exp_cnt));
   endtask

   initial begin
      rst           = 1'b0;
      bus.en        = 1'b1;
      bus.req_valid = 4'hF;
      bus.req_last  = 4'hF;
      bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      bus.fifo_full = 1'b0;

      // Reset holds everything off even with all requesters valid.
      step();
      chk_grant("rst", 4'b0000, 8'h00);
      chk_regs("rst", 1'b0, 2'd0, 3'd0);
      step();
      rst = 1'b1;

      // Round-robin of single-beat packets: 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         chk_grant($sformatf("rr%0d", k), 4'(1 << (k % 4)), 8'(8'hA0 + (k % 4)));
         step();
         chk($sformatf("rr%0d_owner", k), 32'(bus.owner), 32'(k % 4));
      end
      bus.req_valid = 4'b0000;
      chk_grant("quiet", 4'b0000, 8'h00);
      step();

      // req1 holds the grant for 3 beats while req2 waits (rr_ptr=1).
      bus.req_valid = 4'b0110;
      bus.req_last  = 4'b0000;
      chk_grant("lk_b1", 4'b0010, 8'hA1);
      step();
      chk_regs("lk_b1", 1'b1, 2'd1, 3'd1);
      chk_grant("lk_b2", 4'b0010, 8'hA1);
      step();
      chk_regs("lk_b2", 1'b1, 2'd1, 3'd2);
      bus.req_last = 4'b0010;
      chk_grant("lk_b3", 4'b0010, 8'hA1);
      step();
      chk_regs("lk_end", 1'b0, 2'd1, 3'd0);
      bus.req_valid = 4'b0100;
      bus.req_last  = 4'b0100;
      chk_grant("lk_req2", 4'b0100, 8'hA2);
      step();

      // FIFO full mid-packet on req3 (rr_ptr=3).
      bus.req_valid = 4'b1000;
      bus.req_last  = 4'b0000;
      chk_grant("fl_b1", 4'b1000, 8'hA3);
      step();
      bus.fifo_full = 1'b1;
      chk_grant("fl_stall0", 4'b0000, 8'h00);
      step();
      chk_regs("fl_stall0", 1'b1, 2'd3, 3'd1);
      chk_grant("fl_stall1", 4'b0000, 8'h00);
      step();
      chk_regs("fl_stall1", 1'b1, 2'd3, 3'd1);
      bus.fifo_full = 1'b0;
      bus.req_last  = 4'b1000;
      chk_grant("fl_b2", 4'b1000, 8'hA3);
      step();
      chk_regs("fl_end", 1'b0, 2'd3, 3'd0);

      // Forced release after MAX_BURST=4 beats of req0; req3 slips in (rr_ptr=0).
      bus.req_valid = 4'b1001;
      bus.req_last  = 4'b0000;
      for (int b = 1; b <= 3; b++) begin
         chk_grant($sformatf("mb_b%0d", b), 4'b0001, 8'hA0);
         step();
         chk($sformatf("mb_b%0d_cnt", b), 32'(bus.burst_cnt), 32'(b));
      end
      chk_grant("mb_b4", 4'b0001, 8'hA0);
      step();
      chk_regs("mb_rel", 1'b0, 2'd0, 3'd0);
      bus.req_last = 4'b1000;
      chk_grant("mb_req3", 4'b1000, 8'hA3);
      step();
      chk_regs("mb_req3", 1'b0, 2'd3, 3'd0);
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0000;
      chk_grant("mb_b5", 4'b0001, 8'hA0);
      step();
      chk_regs("mb_b5", 1'b1, 2'd0, 3'd1);
      bus.req_last = 4'b0001;
      chk_grant("mb_b6", 4'b0001, 8'hA0);
      step();
      chk_regs("mb_end", 1'b0, 2'd0, 3'd0);

      // en=0 in IDLE blocks grants (rr_ptr=1).
      bus.en        = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_last  = 4'hF;
      chk_grant("en_idle", 4'b0000, 8'h00);
      step();
      chk_regs("en_idle", 1'b0, 2'd0, 3'd0);

      // en=0 while LOCKED lets req2's packet finish, then nothing further.
      bus.en        = 1'b1;
      bus.req_valid = 4'b0100;
      bus.req_last  = 4'b0000;
      chk_grant("en_b1", 4'b0100, 8'hA2);
      step();
      bus.en = 1'b0;
      chk_grant("en_b2", 4'b0100, 8'hA2);
      step();
      chk_regs("en_b2", 1'b1, 2'd2, 3'd2);
      bus.req_last = 4'b0100;
      chk_grant("en_b3", 4'b0100, 8'hA2);
      step();
      bus.req_valid = 4'hF;
      chk_grant("en_after", 4'b0000, 8'h00);
      step();
      chk_regs("en_after", 1'b0, 2'd2, 3'd0);

      // Reset mid-packet clears state immediately (rr_ptr=3, only req0 valid).
      bus.en        = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0000;
      chk_grant("mr_b1", 4'b0001, 8'hA0);
      step();
      chk_regs("mr_b1", 1'b1, 2'd0, 3'd1);
      rst = 1'b0;
      chk_grant("mr_rst", 4'b0000, 8'h00);
      chk_regs("mr_rst", 1'b0, 2'd0, 3'd0);
      step();
      rst = 1'b1;
      chk_grant("mr_regrant", 4'b0001, 8'hA0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
